// File: rtl/hwag_out_bank.sv
// Angle-window output bank: per-channel shadow/active window pairs committed at angle wrap,
// with registered, optionally paired (wasted-spark) channel outputs.
module hwag_out_bank #(
  parameter int unsigned CH        = 4,
  parameter int unsigned AW        = 24,
  parameter int unsigned ANGLE_TOP = 7679
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         angle,
  input  logic                  angle_valid,
  input  logic                  phased,
  input  logic [CH-1:0]         ch_en,
  input  logic                  wr_en,
  input  logic [$clog2(CH)-1:0] wr_ch,
  input  logic [AW-1:0]         wr_set,
  input  logic [AW-1:0]         wr_reset,
  output logic [CH-1:0]         pend,
  output logic [CH-1:0]         out
);

  localparam int unsigned CW   = $clog2(CH);
  localparam int unsigned HALF = CH / 2;

  // Elaboration-time parameter sanity checks
  generate
    if ((CH < 2) || ((CH % 2) != 0)) begin : g_bad_ch
      $error("hwag_out_bank: CH must be even and >= 2");
    end
    if (64'(ANGLE_TOP) >= (64'd1 << AW)) begin : g_bad_top
      $error("hwag_out_bank: ANGLE_TOP does not fit in AW bits");
    end
  endgenerate

  logic [AW-1:0] angle_d;
  logic [AW-1:0] sh_set    [CH];
  logic [AW-1:0] sh_reset  [CH];
  logic [AW-1:0] ac_set    [CH];
  logic [AW-1:0] ac_reset  [CH];
  logic [AW-1:0] eff_set   [CH];
  logic [AW-1:0] eff_reset [CH];
  logic [CH-1:0] win_c;
  logic [CH-1:0] out_nxt;
  logic [CH-1:0] wr_hit;
  logic          wr_ok;
  logic          commit;

  // Wrap or loss of sync commits every pending shadow
  assign commit = ~angle_valid | (angle < angle_d);

  // Out-of-range channel indices only exist when CH is not a power of two
  generate
    if ((1 << CW) > CH) begin : g_rng
      assign wr_ok = wr_en & (wr_ch < CW'(CH));
    end else begin : g_full
      assign wr_ok = wr_en;
    end
  endgenerate

  assign wr_hit = wr_ok ? (CH'(1) << wr_ch) : '0;

  generate
    for (genvar i = 0; i < CH; i++) begin : g_ch
      localparam int unsigned P = (i < HALF) ? (i + HALF) : (i - HALF);

      // Windows committed this cycle already apply to this cycle's angle
      assign eff_set[i]   = (commit & pend[i]) ? sh_set[i]   : ac_set[i];
      assign eff_reset[i] = (commit & pend[i]) ? sh_reset[i] : ac_reset[i];

      assign win_c[i] = (eff_set[i] < eff_reset[i]) ? ((angle >= eff_set[i]) && (angle < eff_reset[i])) :
                        (eff_set[i] > eff_reset[i]) ? ((angle >= eff_set[i]) || (angle < eff_reset[i])) :
                        1'b0;

      assign out_nxt[i] = angle_valid & ch_en[i] & (phased ? win_c[i] : (win_c[i] | win_c[P]));
    end
  endgenerate

  // State: angle history, pending flags, shadow/active windows, outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      angle_d <= '0;
      pend    <= '0;
      out     <= '0;
      for (int i = 0; i < CH; i++) begin
        sh_set[i]   <= '0;
        sh_reset[i] <= '0;
        ac_set[i]   <= '0;
        ac_reset[i] <= '0;
      end
    end else begin
      angle_d <= angle;
      out     <= out_nxt;
      pend    <= (commit ? '0 : pend) | wr_hit;
      for (int i = 0; i < CH; i++) begin
        ac_set[i]   <= eff_set[i];
        ac_reset[i] <= eff_reset[i];
        if (wr_hit[i]) begin
          sh_set[i]   <= wr_set;
          sh_reset[i] <= wr_reset;
        end
      end
    end
  end

endmodule

// File: tb/tb_hwag_out_bank.sv
// Self-checking bench for hwag_out_bank against a window-arithmetic reference model.
module tb_hwag_out_bank;

  localparam int TOP = 7679;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] angle;
  logic        angle_valid;
  logic        phased;
  logic [3:0]  ch_en;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [23:0] wr_set;
  logic [23:0] wr_reset;
  logic [3:0]  pend;
  logic [3:0]  out;

  logic [5:0]  ch_en6;
  logic        wr_en6;
  logic [2:0]  wr_ch6;
  logic [5:0]  pend6;
  logic [5:0]  out6;

  int errors = 0;
  int checks = 0;

  logic [23:0] m_sh_s [4];
  logic [23:0] m_sh_r [4];
  logic [23:0] m_ac_s [4];
  logic [23:0] m_ac_r [4];
  logic [3:0]  m_pend;
  logic [3:0]  m_out;
  logic [23:0] m_angle_d;

  always #5 clk = ~clk;

  hwag_out_bank #(.CH(4), .AW(24), .ANGLE_TOP(TOP)) u_dut (
    .clk(clk), .rst(rst), .angle(angle), .angle_valid(angle_valid), .phased(phased),
    .ch_en(ch_en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_set(wr_set), .wr_reset(wr_reset),
    .pend(pend), .out(out)
  );

  hwag_out_bank #(.CH(6), .AW(24), .ANGLE_TOP(TOP)) u_dut6 (
    .clk(clk), .rst(rst), .angle(angle), .angle_valid(angle_valid), .phased(phased),
    .ch_en(ch_en6), .wr_en(wr_en6), .wr_ch(wr_ch6), .wr_set(wr_set), .wr_reset(wr_reset),
    .pend(pend6), .out(out6)
  );

  // A window is the arc of length (reset - set) mod 2^24 starting at set
  function automatic bit in_win(logic [23:0] a, logic [23:0] s, logic [23:0] r);
    logic [23:0] d;
    logic [23:0] len;
    if (s == r) return 1'b0;
    d   = a - s;
    len = r - s;
    return d < len;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_sh_s[i] = '0; m_sh_r[i] = '0; m_ac_s[i] = '0; m_ac_r[i] = '0;
    end
    m_pend    = '0;
    m_out     = '0;
    m_angle_d = '0;
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT
  task automatic tick();
    bit       com;
    bit [3:0] w;
    com = !angle_valid || (angle < m_angle_d);
    if (com) begin
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i]) begin
          m_ac_s[i] = m_sh_s[i];
          m_ac_r[i] = m_sh_r[i];
        end
      end
      m_pend = '0;
    end
    for (int i = 0; i < 4; i++) w[i] = in_win(angle, m_ac_s[i], m_ac_r[i]);
    for (int i = 0; i < 4; i++)
      m_out[i] = angle_valid & ch_en[i] & (phased ? w[i] : (w[i] | w[(i + 2) % 4]));
    if (wr_en) begin
      m_sh_s[wr_ch] = wr_set;
      m_sh_r[wr_ch] = wr_reset;
      m_pend[wr_ch] = 1'b1;
    end
    m_angle_d = angle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (out !== 4'b0 || pend !== 4'b0) begin
      errors++; $display("FAIL reset_state out=%b pend=%b expected 0000/0000", out, pend);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    model_clear();
    m_angle_d = angle;
    tick();
    checks++;
    if (out !== m_out || pend !== m_pend) begin
      errors++; $display("FAIL post_reset out=%b/%b pend=%b/%b", out, m_out, pend, m_pend);
    end
  endtask

  task automatic test_basic();
    int hi = 0;
    int first = -1;
    phased = 1'b1; ch_en = 4'hF; angle_valid = 1'b0; angle = '0;
    wr_en = 1'b1; wr_ch = 2'd0; wr_set = 24'd1152; wr_reset = 24'd1216;
    tick();
    wr_en = 1'b0;
    checks++;
    if (pend !== 4'b0001 || pend !== m_pend) begin
      errors++; $display("FAIL basic_pend_set pend=%b expected 0001", pend);
    end
    tick();
    checks++;
    if (pend !== 4'b0000) begin
      errors++; $display("FAIL basic_pend_clear pend=%b expected 0000", pend);
    end
    angle_valid = 1'b1;
    for (int k = 0; k <= TOP; k++) begin
      angle = 24'(k);
      tick();
      checks++;
      if (out !== m_out || pend !== m_pend) begin
        errors++; $display("FAIL basic_sweep angle=%0d out=%b/%b pend=%b/%b", k, out, m_out, pend, m_pend);
      end
      if (out[0]) begin
        hi++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (hi != 64 || first != 1152) begin
      errors++; $display("FAIL basic_window width=%0d start=%0d expected 64/1152", hi, first);
    end
  endtask

  task automatic test_wrap_window();
    int hi = 0;
    for (int k = 0; k <= TOP; k++) begin
      angle = 24'(k);
      if (k == 100) begin
        wr_en = 1'b1; wr_ch = 2'd1; wr_set = 24'd7600; wr_reset = 24'd64;
      end
      tick();
      wr_en = 1'b0;
      checks++;
      if (out !== m_out || pend !== m_pend) begin
        errors++; $display("FAIL wrapwin_sweep1 angle=%0d out=%b/%b pend=%b/%b", k, out, m_out, pend, m_pend);
      end
      if (out[1]) hi++;
    end
    checks++;
    if (pend[1] !== 1'b1 || hi != 0) begin
      errors++; $display("FAIL wrapwin_pending pend1=%b hits=%0d expected 1/0", pend[1], hi);
    end
    hi = 0;
    for (int k = 0; k <= TOP; k++) begin
      angle = 24'(k);
      tick();
      checks++;
      if (out !== m_out || pend !== m_pend) begin
        errors++; $display("FAIL wrapwin_sweep2 angle=%0d out=%b/%b pend=%b/%b", k, out, m_out, pend, m_pend);
      end
      if (out[1]) hi++;
    end
    checks++;
    if (hi != 144 || pend[1] !== 1'b0) begin
      errors++; $display("FAIL wrapwin_width width=%0d pend1=%b expected 144/0", hi, pend[1]);
    end
  endtask

  task automatic test_paired();
    int c0 = 0, c1 = 0, c2 = 0, c3 = 0;
    phased = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k <= TOP; k++) begin
        angle = 24'(k);
        if (pass == 0 && k == 0) begin
          wr_en = 1'b1; wr_ch = 2'd2; wr_set = 24'd4992; wr_reset = 24'd5056;
        end
        tick();
        wr_en = 1'b0;
        checks++;
        if (out !== m_out || pend !== m_pend) begin
          errors++; $display("FAIL paired_sweep angle=%0d out=%b/%b pend=%b/%b", k, out, m_out, pend, m_pend);
        end
        if (pass == 1) begin
          c0 += int'(out[0]); c1 += int'(out[1]); c2 += int'(out[2]); c3 += int'(out[3]);
        end
      end
    end
    checks++;
    if (c0 != 128 || c2 != 128 || c1 != 144 || c3 != 144) begin
      errors++; $display("FAIL paired_widths got %0d/%0d/%0d/%0d expected 128/144/128/144", c0, c1, c2, c3);
    end
  endtask

  task automatic test_wrap_write();
    int hi = 0;
    phased = 1'b1;
    angle = 24'd0;
    wr_en = 1'b1; wr_ch = 2'd0; wr_set = 24'd2000; wr_reset = 24'd2100;
    tick();
    wr_en = 1'b0;
    checks++;
    if (pend[0] !== 1'b1 || pend !== m_pend) begin
      errors++; $display("FAIL wrapwrite_pend pend=%b/%b", pend, m_pend);
    end
    for (int k = 1; k <= TOP; k++) begin
      angle = 24'(k);
      tick();
      checks++;
      if (out !== m_out || pend !== m_pend) begin
        errors++; $display("FAIL wrapwrite_old angle=%0d out=%b/%b", k, out, m_out);
      end
      if (out[0]) hi++;
    end
    checks++;
    if (hi != 64) begin
      errors++; $display("FAIL wrapwrite_oldwidth width=%0d expected 64", hi);
    end
    hi = 0;
    for (int k = 0; k <= TOP; k++) begin
      angle = 24'(k);
      tick();
      checks++;
      if (out !== m_out || pend !== m_pend) begin
        errors++; $display("FAIL wrapwrite_new angle=%0d out=%b/%b", k, out, m_out);
      end
      if (out[0]) hi++;
    end
    checks++;
    if (hi != 100 || pend[0] !== 1'b0) begin
      errors++; $display("FAIL wrapwrite_newwidth width=%0d pend0=%b expected 100/0", hi, pend[0]);
    end
  endtask

  task automatic test_valid_drop();
    for (int k = 0; k <= 2050; k++) begin
      angle = 24'(k);
      tick();
      checks++;
      if (out !== m_out) begin
        errors++; $display("FAIL drop_lead angle=%0d out=%b/%b", k, out, m_out);
      end
    end
    checks++;
    if (out[0] !== 1'b1) begin
      errors++; $display("FAIL drop_inwin out0=%b expected 1", out[0]);
    end
    angle_valid = 1'b0;
    tick();
    checks++;
    if (out !== 4'b0000) begin
      errors++; $display("FAIL drop_forced out=%b expected 0000", out);
    end
    angle_valid = 1'b1;
    tick();
    checks++;
    if (out !== m_out || out[0] !== 1'b1) begin
      errors++; $display("FAIL drop_recover out=%b/%b", out, m_out);
    end
  endtask

  task automatic test_async_reset();
    int hi = 0;
    wr_en = 1'b1; wr_ch = 2'd1; wr_set = 24'd10; wr_reset = 24'd20;
    tick();
    wr_en = 1'b0;
    checks++;
    if (pend[1] !== 1'b1 || out[0] !== 1'b1) begin
      errors++; $display("FAIL areset_pre pend=%b out=%b expected pend1=1 out0=1", pend, out);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out !== 4'b0000 || pend !== 4'b0000) begin
      errors++; $display("FAIL areset_immediate out=%b pend=%b expected 0000/0000", out, pend);
    end
    model_clear();
    #1;
    rst = 1'b1;
    m_angle_d = 24'd2050;
    for (int k = 2050; k <= TOP + 2050; k++) begin
      angle = 24'(k % (TOP + 1));
      tick();
      checks++;
      if (out !== m_out || pend !== m_pend) begin
        errors++; $display("FAIL areset_sweep angle=%0d out=%b/%b", k, out, m_out);
      end
      if (out != 4'b0) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++; $display("FAIL areset_empty active=%0d expected 0", hi);
    end
  endtask

  task automatic test_empty_and_badch();
    int hi = 0;
    wr_en = 1'b1; wr_ch = 2'd3; wr_set = 24'd500; wr_reset = 24'd500;
    tick();
    wr_en = 1'b0;
    angle_valid = 1'b0;
    tick();
    angle_valid = 1'b1;
    for (int k = 0; k <= 1000; k++) begin
      angle = 24'(k);
      tick();
      checks++;
      if (out !== m_out || pend !== m_pend) begin
        errors++; $display("FAIL empty_sweep angle=%0d out=%b/%b", k, out, m_out);
      end
      if (out[3]) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++; $display("FAIL empty_window width=%0d expected 0", hi);
    end
    wr_set = 24'd300; wr_reset = 24'd400;
    for (int c = 6; c <= 7; c++) begin
      wr_en6 = 1'b1; wr_ch6 = 3'(c);
      tick();
      wr_en6 = 1'b0;
      checks++;
      if (pend6 !== 6'b0) begin
        errors++; $display("FAIL badch_%0d pend6=%b expected 000000", c, pend6);
      end
    end
    wr_en6 = 1'b1; wr_ch6 = 3'd5;
    tick();
    wr_en6 = 1'b0;
    checks++;
    if (pend6 !== 6'b100000) begin
      errors++; $display("FAIL goodch_5 pend6=%b expected 100000", pend6);
    end
  endtask

  task automatic test_random();
    angle = 24'($urandom_range(7000, TOP));
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 3) angle_valid = ~angle_valid;
      if (!angle_valid && $urandom_range(0, 3) == 0) angle = 24'($urandom_range(7500, TOP));
      else if ($urandom_range(0, 4) != 0) angle = (angle == 24'(TOP)) ? 24'd0 : angle + 24'd1;
      if ($urandom_range(0, 49) == 0) phased = ~phased;
      if ($urandom_range(0, 49) == 0) ch_en = 4'($urandom);
      wr_en    = ($urandom_range(0, 19) == 0);
      wr_ch    = 2'($urandom);
      wr_set   = 24'($urandom_range(0, TOP));
      wr_reset = ($urandom_range(0, 9) == 0) ? wr_set : 24'($urandom_range(0, TOP));
      tick();
      wr_en = 1'b0;
      checks++;
      if (out !== m_out || pend !== m_pend) begin
        errors++; $display("FAIL random n=%0d angle=%0d out=%b/%b pend=%b/%b", n, angle, out, m_out, pend, m_pend);
      end
    end
  endtask

  initial begin
    rst = 1'b0; angle = '0; angle_valid = 1'b0; phased = 1'b1; ch_en = 4'hF;
    wr_en = 1'b0; wr_ch = '0; wr_set = '0; wr_reset = '0;
    ch_en6 = '1; wr_en6 = 1'b0; wr_ch6 = '0;
    model_clear();
    test_reset();
    test_basic();
    test_wrap_window();
    test_paired();
    test_wrap_write();
    test_valid_drop();
    test_async_reset();
    test_empty_and_badch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
